random_countdown: RTL and testbench

RANDOM_COUNTDOWN -- requirements
Module: random_countdown

---
 rtl/countdown_pkg.sv | 23 ++
 rtl/sseg_scan.sv | 58 +++++
 rtl/random_countdown.sv | 127 ++++++++++++
 tb/tb_random_countdown.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the random countdown timer: FSM state
// encoding, hex-to-seven-segment table and blank display patterns.
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Active-low segments, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_BLANK  = 8'hFF;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

endpackage

// File: rtl/sseg_scan.sv
// Multiplexed seven-segment scanner: steps through NUM_DIGITS hex digits of
// the input value, one every SCAN_DIV clocks, driving active-low anodes.
module sseg_scan
   import countdown_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int SCAN_DIV   = 100_000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [6:0]              sseg,
   output logic [7:0]              an
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [3:0]       digit;

   // Scan divider and digit index advance
   always_comb begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
         div_d = '0;
         if (idx_q == IDX_W'(NUM_DIGITS - 1)) idx_d = '0;
         else                                 idx_d = idx_q + IDX_W'(1);
      end
   end

   // Scan registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
         idx_q <= '0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
      end
   end

   // Digit select and decode; anodes beyond NUM_DIGITS never go low
   always_comb begin
      an    = AN_BLANK;
      digit = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            an[i] = 1'b0;
            digit = value[4*i +: 4];
         end
      end
      sseg = SEG_TABLE[digit];
   end

endmodule

// File: rtl/random_countdown.sv
// Random-start countdown timer. A free-running range counter supplies the
// pseudo-random start value captured on start; the count then decrements
// once every TICK_DIV clocks until it reaches zero.
// Optional display: define RANDOM_COUNTDOWN_DISPLAY_EN to build the hex
// scanner; otherwise sseg/an are tied to blank.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | counting down, prescaler advancing
// PAUSE | stop held, count and prescaler frozen
// DONE  | count reached zero, countdone high until next start
module random_countdown
   import countdown_pkg::*;
#(
   parameter int CNT_W      = 5,
   parameter int MIN_START  = 2,
   parameter int MAX_START  = 15,
   parameter int TICK_DIV   = 100_000_000,
   parameter int NUM_DIGITS = 2,
   parameter int SCAN_DIV   = 100_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             start,
   input  logic             stop,
   output logic [CNT_W-1:0] count,
   output logic             busy,
   output logic             countdone,
   output logic [6:0]       sseg,
   output logic [7:0]       an
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rng_q, rng_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             busy_q, busy_d;
   logic             countdone_q, countdone_d;

   // Range counter runs every clock so the start value depends on when start arrives
   always_comb begin
      if (rng_q == CNT_W'(MAX_START)) rng_d = CNT_W'(MIN_START);
      else                            rng_d = rng_q + CNT_W'(1);
   end

   // Next-state, count and prescaler; en low holds everything but the range counter
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pre_d   = pre_q;
      if (en) begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  count_d = rng_q;
                  pre_d   = '0;
                  state_d = stop ? ST_PAUSE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  state_d = ST_PAUSE;
               end else if (pre_q == PRE_W'(TICK_DIV - 1)) begin
                  pre_d   = '0;
                  count_d = count_q - CNT_W'(1);
                  if (count_q == CNT_W'(1)) state_d = ST_DONE;
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
            end
            ST_PAUSE: begin
               if (!stop) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      busy_d      = (state_d == ST_RUN) || (state_d == ST_PAUSE);
      countdone_d = (state_d == ST_DONE);
   end

   // FSM and datapath registers with registered status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rng_q       <= CNT_W'(MIN_START);
         count_q     <= '0;
         pre_q       <= '0;
         busy_q      <= 1'b0;
         countdone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rng_q       <= rng_d;
         count_q     <= count_d;
         pre_q       <= pre_d;
         busy_q      <= busy_d;
         countdone_q <= countdone_d;
      end
   end

   assign count     = count_q;
   assign busy      = busy_q;
   assign countdone = countdone_q;

`ifdef RANDOM_COUNTDOWN_DISPLAY_EN
   logic [4*NUM_DIGITS-1:0] disp_val;

   assign disp_val = (4*NUM_DIGITS)'(count_q);

   sseg_scan #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) u_sseg_scan (
      .clk     (clk),
      .reset_n (reset_n),
      .value   (disp_val),
      .sseg    (sseg),
      .an      (an)
   );
`else
   assign sseg = SEG_BLANK;
   assign an   = AN_BLANK;
`endif

endmodule

// File: tb/tb_random_countdown.sv
// Self-checking bench for random_countdown with TICK_DIV=4, SCAN_DIV=2.
module tb_random_countdown;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [4:0] count;
   logic       busy;
   logic       countdone;
   logic [6:0] sseg;
   logic [7:0] an;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   random_countdown #(
      .CNT_W      (5),
      .MIN_START  (2),
      .MAX_START  (15),
      .TICK_DIV   (4),
      .NUM_DIGITS (2),
      .SCAN_DIV   (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .start     (start),
      .stop      (stop),
      .count     (count),
      .busy      (busy),
      .countdone (countdone),
      .sseg      (sseg),
      .an        (an)
   );

   always #5 clk = ~clk;

   typedef struct {
      int k;        // edge after release on which start is high
      int exp_cnt;  // loaded count
      int exp_clk;  // clocks from load to countdone
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   task automatic do_reset();
      start   = 1'b0;
      stop    = 1'b0;
      en      = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      edge_cnt = 0;
   endtask

   task automatic start_at(input int k);
      start = 1'b0;
      repeat (k - 1) step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!countdone && n < 200) begin
         step();
         n++;
      end
   endtask

   // Display expectation: scan index toggles every 2 edges after release
   task automatic disp_chk(input int dig0_seg, input int dig1_seg);
      int idx;
      idx = (edge_cnt / 2) % 2;
`ifdef RANDOM_COUNTDOWN_DISPLAY_EN
      chk("an", int'(an), idx ? 8'hFD : 8'hFE);
      chk("sseg", int'(sseg), idx ? dig1_seg : dig0_seg);
`else
      chk("an_blank", int'(an), 8'hFF);
      chk("sseg_blank", int'(sseg), 7'h7F);
`endif
   endtask

   initial begin
      int n;
      int exp;
      logic saw_done;

      vecs[0] = '{k: 1,  exp_cnt: 2,  exp_clk: 8};
      vecs[1] = '{k: 5,  exp_cnt: 6,  exp_clk: 24};
      vecs[2] = '{k: 14, exp_cnt: 15, exp_clk: 60};
      vecs[3] = '{k: 15, exp_cnt: 2,  exp_clk: 8};
      vecs[4] = '{k: 16, exp_cnt: 3,  exp_clk: 12};

      // Reset state
      do_reset();
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(countdone), 0);
      disp_chk(7'h40, 7'h40);

      // Table: start edge selects the random value, run length is count*4
      for (int v = 0; v < 5; v++) begin
         do_reset();
         start_at(vecs[v].k);
         chk("load_count", int'(count), vecs[v].exp_cnt);
         chk("load_busy", int'(busy), 1);
         wait_done(n);
         chk("run_clocks", n, vecs[v].exp_clk);
         chk("done_count", int'(count), 0);
         chk("done_busy", int'(busy), 0);
      end

      // Decrement edges at +4 and +8 after a first-edge start
      do_reset();
      start_at(1);
      repeat (3) step();
      chk("pre_tick_count", int'(count), 2);
      step();
      chk("tick1_count", int'(count), 1);
      repeat (3) step();
      chk("pre_tick2_done", int'(countdone), 0);
      step();
      chk("tick2_done", int'(countdone), 1);
      chk("tick2_count", int'(count), 0);

      // Pause on a tick cycle, then resume from the held prescaler
      do_reset();
      start_at(5);
      repeat (4) step();
      chk("pause_pre_count", int'(count), 5);
      repeat (3) step();
      stop = 1'b1;
      step();
      chk("pause_count", int'(count), 5);
      chk("pause_busy", int'(busy), 1);
      repeat (9) step();
      chk("pause_hold", int'(count), 5);
      stop = 1'b0;
      step();
      chk("resume_count", int'(count), 5);
      step();
      chk("resume_tick", int'(count), 4);
      wait_done(n);
      chk("resume_clocks", n, 16);

      // en low freezes a run; start is ignored while running
      do_reset();
      start_at(1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_ignored", int'(count), 2);
      step();
      en    = 1'b0;
      stop  = 1'b1;
      start = 1'b1;
      repeat (7) step();
      chk("en_hold_count", int'(count), 2);
      chk("en_hold_busy", int'(busy), 1);
      en    = 1'b1;
      stop  = 1'b0;
      start = 1'b0;
      wait_done(n);
      chk("en_ext_clocks", n, 6);
      repeat (5) step();
      chk("done_hold", int'(countdone), 1);
      chk("done_hold_cnt", int'(count), 0);
      exp = 2 + (edge_cnt % 14);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_count", int'(count), exp);
      chk("restart_done", int'(countdone), 0);
      chk("restart_busy", int'(busy), 1);

      // Start with stop high goes straight to PAUSE; display follows count
      do_reset();
      stop = 1'b1;
      start_at(5);
      chk("start_pause_count", int'(count), 6);
      chk("start_pause_busy", int'(busy), 1);
      for (int i = 0; i < 4; i++) begin
         disp_chk(7'h02, 7'h40);
         step();
      end
      chk("start_pause_hold", int'(count), 6);
      stop = 1'b0;

      // Asynchronous reset mid-run aborts without a countdone pulse
      do_reset();
      start_at(5);
      repeat (12) step();
      chk("pre_reset_count", int'(count), 3);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_count", int'(count), 0);
      chk("async_busy", int'(busy), 0);
      chk("async_done", int'(countdone), 0);
      saw_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n  = 1'b1;
      edge_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (countdone) saw_done = 1'b1;
      end
      chk("no_done_after_rst", int'(saw_done), 0);
      chk("idle_busy", int'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
